// File: rtl/jtframe_upload_if.sv
// jtframe_upload_if
//   Groups the two buses of the upload reader.
//   HPS side : ioctl_upload, ioctl_rd, ioctl_addr (to reader), ioctl_din, ioctl_wait (from reader)
//   SDRAM side: prog_addr, prog_rd (from reader), prog_data, prog_rdy (to reader)
//   Modport slave is the reader's view of both buses.
//   Modport master is the surrounding system's view: HPS plus SDRAM controller.
interface jtframe_upload_if;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [21:0] prog_addr;
    logic        prog_rd;
    logic [15:0] prog_data;
    logic        prog_rdy;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait,
        output prog_addr, prog_rd,
        input  prog_data, prog_rdy
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait,
        input  prog_addr, prog_rd,
        output prog_data, prog_rdy
    );
endinterface

// File: rtl/jtframe_upload.sv
// jtframe_upload
//   Serves HPS upload byte reads from SDRAM through a one-word cache.
//   A cache hit answers on the next edge without raising ioctl_wait. A miss
//   issues a level read on prog_rd (word address + BASE) and waits for
//   prog_rdy, giving up after TIMEOUT cycles and returning 8'hFF.
// Ports
//   clk_sys     : system clock, rising edge
//   RESET       : asynchronous, active-high reset
//   bus         : jtframe_upload_if.slave, HPS ioctl bus and SDRAM prog bus
//   busy        : a read is in flight (REQ or WAIT)
//   timeout_err : sticky, a read timed out during this upload session
//   overrun_err : sticky, an ioctl_rd arrived while busy
module jtframe_upload #(
    parameter logic [21:0] BASE    = 22'h0,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic             clk_sys,
    input  logic             RESET,
    jtframe_upload_if.slave  bus,
    output logic             busy,
    output logic             timeout_err,
    output logic             overrun_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [20:0] cache_addr;
    logic [15:0] cache_data;
    logic        cache_valid;
    logic        byte_sel;
    logic [7:0]  cnt;
    logic        upload_q;

    logic        upload_fall;
    logic        upload_rise;
    logic        rd_req;
    logic        hit;
    logic [21:0] req_addr;
    logic [7:0]  hit_byte;
    logic [7:0]  fill_byte;

    assign upload_fall = upload_q & ~bus.ioctl_upload;
    assign upload_rise = ~upload_q & bus.ioctl_upload;
    assign rd_req      = bus.ioctl_rd & bus.ioctl_upload;
    // A new session invalidates the cache in the same edge, so never hit on it
    assign hit         = cache_valid & ~upload_rise & (bus.ioctl_addr[21:1] == cache_addr);
    assign req_addr    = {1'b0, bus.ioctl_addr[21:1]} + BASE;
    assign hit_byte    = bus.ioctl_addr[0] ? cache_data[15:8] : cache_data[7:0];
    assign fill_byte   = byte_sel ? bus.prog_data[15:8] : bus.prog_data[7:0];
    assign busy        = (state != IDLE);

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state          <= IDLE;
            bus.ioctl_din  <= 8'h00;
            bus.ioctl_wait <= 1'b0;
            bus.prog_rd    <= 1'b0;
            bus.prog_addr  <= 22'h0;
            cache_addr     <= 21'h0;
            cache_data     <= 16'h0;
            cache_valid    <= 1'b0;
            byte_sel       <= 1'b0;
            cnt            <= 8'h0;
            upload_q       <= 1'b0;
            timeout_err    <= 1'b0;
            overrun_err    <= 1'b0;
        end else begin
            upload_q <= bus.ioctl_upload;
            if (upload_fall) begin
                // End of session: abort anything in flight, a late prog_rdy lands in IDLE
                state          <= IDLE;
                bus.prog_rd    <= 1'b0;
                bus.ioctl_wait <= 1'b0;
                cache_valid    <= 1'b0;
                timeout_err    <= 1'b0;
                overrun_err    <= 1'b0;
            end else begin
                if (upload_rise) begin
                    cache_valid <= 1'b0;
                    timeout_err <= 1'b0;
                    overrun_err <= 1'b0;
                end
                if (rd_req && state != IDLE) begin
                    overrun_err <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (rd_req) begin
                            if (hit) begin
                                bus.ioctl_din <= hit_byte;
                            end else begin
                                state          <= REQ;
                                bus.ioctl_wait <= 1'b1;
                                bus.prog_rd    <= 1'b1;
                                bus.prog_addr  <= req_addr;
                                byte_sel       <= bus.ioctl_addr[0];
                            end
                        end
                    end
                    REQ: begin
                        state <= WAIT;
                        cnt   <= 8'h0;
                    end
                    WAIT: begin
                        if (bus.prog_rdy) begin
                            // Low 21 bits of (prog_addr - BASE) recover the word address
                            cache_data     <= bus.prog_data;
                            cache_addr     <= bus.prog_addr[20:0] - BASE[20:0];
                            cache_valid    <= 1'b1;
                            bus.ioctl_din  <= fill_byte;
                            bus.prog_rd    <= 1'b0;
                            bus.ioctl_wait <= 1'b0;
                            state          <= IDLE;
                        end else if (cnt == TIMEOUT) begin
                            bus.ioctl_din  <= 8'hFF;
                            timeout_err    <= 1'b1;
                            bus.prog_rd    <= 1'b0;
                            bus.ioctl_wait <= 1'b0;
                            state          <= IDLE;
                        end else if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_upload.sv
// tb_jtframe_upload
//   Two readers share one stimulus stream: u0 with BASE=0, u1 with a BASE that
//   makes high word addresses wrap. Both use TIMEOUT=10 so they stay in step.
//   Reads push expected results into a queue; a monitor pops and checks them.
module tb_jtframe_upload;

    localparam logic [21:0] BASE0 = 22'h000000;
    localparam logic [21:0] BASE1 = 22'h300000;
    localparam logic [7:0]  TMO   = 8'd10;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic        upload  = 1'b0;
    logic        rd      = 1'b0;
    logic [21:0] addr    = 22'h0;
    logic [15:0] pdata   = 16'h0;
    logic        prdy    = 1'b0;
    logic        busy0, tmo0, ovr0, busy1, tmo1, ovr1;

    always #5 clk_sys = ~clk_sys;

    jtframe_upload_if u0();
    jtframe_upload_if u1();

    assign u0.ioctl_upload = upload;
    assign u0.ioctl_rd     = rd;
    assign u0.ioctl_addr   = addr;
    assign u0.prog_data    = pdata;
    assign u0.prog_rdy     = prdy;
    assign u1.ioctl_upload = upload;
    assign u1.ioctl_rd     = rd;
    assign u1.ioctl_addr   = addr;
    assign u1.prog_data    = pdata;
    assign u1.prog_rdy     = prdy;

    jtframe_upload #(.BASE(BASE0), .TIMEOUT(TMO)) dut0 (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .bus         (u0),
        .busy        (busy0),
        .timeout_err (tmo0),
        .overrun_err (ovr0)
    );

    jtframe_upload #(.BASE(BASE1), .TIMEOUT(TMO)) dut1 (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .bus         (u1),
        .busy        (busy1),
        .timeout_err (tmo1),
        .overrun_err (ovr1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SDRAM contents as a function of word address
    function automatic logic [15:0] mem_word(input logic [21:0] wa);
        if (wa == 22'h000008) return 16'hBEEF;
        return wa[15:0] * 16'h9E37 + {2'b00, wa[21:16], 8'h5A};
    endfunction

    typedef struct {
        logic [21:0] addr;
        logic        hit;
        logic        tmo;
        logic [7:0]  din;
        logic [21:0] pa0;
        logic [21:0] pa1;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: what the HPS should see, one cached word
    logic        m_valid = 1'b0;
    logic [20:0] m_addr  = 21'h0;
    logic [15:0] m_word  = 16'h0;

    function automatic exp_t make_entry(input logic [21:0] a, input int d);
        exp_t        e;
        logic [20:0] w;
        logic [15:0] word;
        w      = a[21:1];
        e.addr = a;
        e.pa0  = {1'b0, w} + BASE0;
        e.pa1  = {1'b0, w} + BASE1;
        e.hit  = m_valid && (m_addr == w);
        e.tmo  = 1'b0;
        if (e.hit) begin
            word  = m_word;
            e.din = a[0] ? word[15:8] : word[7:0];
        end else if (d < 0) begin
            e.tmo = 1'b1;
            e.din = 8'hFF;
        end else begin
            word    = mem_word({1'b0, w});
            m_word  = word;
            m_addr  = w;
            m_valid = 1'b1;
            e.din   = a[0] ? word[15:8] : word[7:0];
        end
        return e;
    endfunction

    // SDRAM responder: prog_rdy rdy_delay negedges after prog_rd is first seen
    int   rdy_delay  = 1;
    int   rdy_cyc    = 0;
    logic late_pulse = 1'b0;

    initial begin
        logic active;
        logic fired;
        int   wcnt;
        active = 1'b0;
        fired  = 1'b0;
        wcnt   = 0;
        forever begin
            @(negedge clk_sys);
            prdy = 1'b0;
            if (late_pulse) begin
                prdy       = 1'b1;
                pdata      = 16'hDEAD;
                late_pulse = 1'b0;
            end else if (!u0.prog_rd) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    wcnt   = 0;
                    fired  = 1'b0;
                end
                if (rdy_delay >= 0 && !fired && wcnt == rdy_delay) begin
                    prdy    = 1'b1;
                    pdata   = mem_word(u0.prog_addr);
                    rdy_cyc = cyc;
                    fired   = 1'b1;
                end
                wcnt++;
            end
        end
    end

    // Monitor: pops an expectation when an accepted read is presented
    logic mon_busy = 1'b0;

    initial begin
        exp_t e;
        int   n;
        forever begin
            @(posedge clk_sys);
            if (rd && exp_q.size() > 0) begin
                e        = exp_q.pop_front();
                mon_busy = 1'b1;
                rdy_cyc  = -1000;
                @(negedge clk_sys);
                if (e.hit) begin
                    chk("hit_wait", u0.ioctl_wait, 0);
                    chk("hit_prog_rd", u0.prog_rd, 0);
                    chk("hit_din0", u0.ioctl_din, e.din);
                    chk("hit_din1", u1.ioctl_din, e.din);
                end else begin
                    chk("miss_wait", u0.ioctl_wait, 1);
                    chk("miss_prog_rd", u0.prog_rd, 1);
                    chk("miss_paddr0", u0.prog_addr, e.pa0);
                    chk("miss_paddr1", u1.prog_addr, e.pa1);
                    n = 1;
                    while (n < 60) begin
                        @(negedge clk_sys);
                        if (!u0.ioctl_wait) break;
                        chk("prog_rd_held", u0.prog_rd, 1);
                        n++;
                    end
                    chk("wait_fall0", u0.ioctl_wait, 0);
                    chk("wait_fall1", u1.ioctl_wait, 0);
                    chk("prog_rd_drop", u0.prog_rd, 0);
                    chk("miss_din0", u0.ioctl_din, e.din);
                    chk("miss_din1", u1.ioctl_din, e.din);
                    if (e.tmo) begin
                        chk("tmo_len", n, TMO + 2);
                        chk("tmo_flag", tmo0, 1);
                    end else begin
                        chk("rdy_latency", cyc - rdy_cyc, 1);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("resp_bound", n < 200, 1);
        @(negedge clk_sys);
        chk("idle_busy0", busy0, 0);
        chk("idle_busy1", busy1, 0);
    endtask

    // Call right after a negedge
    task automatic do_read(input logic [21:0] a, input int d);
        exp_t e;
        e         = make_entry(a, d);
        rdy_delay = d;
        exp_q.push_back(e);
        addr = a;
        rd   = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
        wait_idle();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_din"}, u0.ioctl_din, 8'h00);
        chk({tag, "_wait"}, u0.ioctl_wait, 0);
        chk({tag, "_prog_rd"}, u0.prog_rd, 0);
        chk({tag, "_prog_addr"}, u0.prog_addr, 22'h0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_tmo"}, tmo0, 0);
        chk({tag, "_ovr"}, ovr0, 0);
        chk({tag, "_prog_rd1"}, u1.prog_rd, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] w;
        logic [20:0] last_w;
        exp_t        e;
        int          d;

        repeat (2) @(negedge clk_sys);
        check_reset_vals("reset");
        RESET = 1'b0;
        @(negedge clk_sys);
        upload = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Miss then hit on the other byte of the same word
        do_read(22'h000010, 5);
        do_read(22'h000011, 2);
        // Word address wraps past 2^22 on u1
        do_read(22'h3FFFFE, 3);
        do_read(22'h3FFFFF, 1);

        // Timeout leaves the cache alone; the same address then misses
        do_read(22'h000200, -1);
        chk("tmo_sticky", tmo0, 1);
        do_read(22'h3FFFFF, 1);
        do_read(22'h000200, 4);

        // Overrun: stray reads mid-WAIT and in the prog_rdy cycle
        e         = make_entry(22'h000040, 6);
        rdy_delay = 6;
        exp_q.push_back(e);
        addr = 22'h000040;
        rd   = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
        repeat (2) @(negedge clk_sys);
        addr = 22'h000080;
        rd   = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
        repeat (3) @(negedge clk_sys);
        addr = 22'h000082;
        rd   = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
        wait_idle();
        chk("ovr_flag0", ovr0, 1);
        chk("ovr_flag1", ovr1, 1);
        do_read(22'h000041, 1);
        do_read(22'h000080, 2);

        // Randomised reads over a small address pool so hits occur
        repeat (40) begin
            if ($urandom_range(0, 1) == 1) w = 21'($urandom_range(0, 5));
            else w = 21'h1FFFFC + 21'($urandom_range(0, 3));
            d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 8));
            do_read({w, 1'($urandom_range(0, 1))}, d);
        end
        chk("tmo_still_set", tmo0, 1);

        // Upload drop mid-WAIT, then a late prog_rdy
        rdy_delay = -1;
        addr = 22'h000300;
        rd   = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk("abort_busy_pre", busy0, 1);
        upload = 1'b0;
        @(negedge clk_sys);
        chk("abort_prog_rd", u0.prog_rd, 0);
        chk("abort_wait", u0.ioctl_wait, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_tmo", tmo0, 0);
        chk("abort_ovr", ovr0, 0);
        last_w  = m_addr;
        m_valid = 1'b0;
        late_pulse = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("late_busy", busy0, 0);
        chk("late_prog_rd", u0.prog_rd, 0);
        chk("late_wait", u0.ioctl_wait, 0);
        // Read with upload low is ignored without a flag
        addr = 22'h000010;
        rd   = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
        @(negedge clk_sys);
        chk("noup_busy", busy0, 0);
        chk("noup_wait", u0.ioctl_wait, 0);
        chk("noup_ovr", ovr0, 0);
        upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        do_read({last_w, 1'b0}, 3);
        do_read(22'h000301, 2);

        // Reset mid-read
        do_read(22'h000500, 2);
        rdy_delay = -1;
        addr = 22'h000600;
        rd   = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
        repeat (3) @(negedge clk_sys);
        #2 RESET = 1'b1;
        #1 check_reset_vals("rst_mid");
        m_valid = 1'b0;
        @(negedge clk_sys);
        late_pulse = 1'b1;
        repeat (2) @(negedge clk_sys);
        check_reset_vals("rst_hold");
        RESET = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("rst_after_prog_rd", u0.prog_rd, 0);
        do_read(22'h000500, 2);
        do_read(22'h000501, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
